rom_loader: RTL

//  Sits between hps_io's ioctl download port and the core's ROM/PROM RAMs. It

---
 rtl/rom_loader_if.sv | 27 ++
 rtl/rom_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rom_loader_if.sv
// ioctl download port and ROM byte-write port of rom_loader.
// master drives the download and the sink stall; slave is the loader.
interface rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        rom_busy;
  logic        rom_wr;
  logic [2:0]  rom_region;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        dl_done;
  logic        dl_err;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_busy,
    input  ioctl_wait, rom_wr, rom_region, rom_addr, rom_data, dl_done, dl_err
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_busy,
    output ioctl_wait, rom_wr, rom_region, rom_addr, rom_data, dl_done, dl_err
  );
endinterface

// File: rtl/rom_loader.sv
// Splits 16-bit ioctl download words into two byte writes, steering each byte
// to its ROM/PROM region with a region-local offset; reports done and overflow.
module rom_loader #(
  parameter logic [7:0]  INDEX   = 8'd0,
  parameter int unsigned CPU_SZ  = 'h14000,
  parameter int unsigned SND_SZ  = 'h08000,
  parameter int unsigned TXT_SZ  = 'h04000,
  parameter int unsigned BG_SZ   = 'h20000,
  parameter int unsigned SPR_SZ  = 'h10000,
  parameter int unsigned MAP_SZ  = 'h08000,
  parameter int unsigned PROM_SZ = 'h00500
) (
  input logic        clk_sys,
  input logic        reset_n,
  rom_loader_if.slave bus
);

  localparam logic [26:0] E0 = 27'(CPU_SZ);
  localparam logic [26:0] E1 = E0 + 27'(SND_SZ);
  localparam logic [26:0] E2 = E1 + 27'(TXT_SZ);
  localparam logic [26:0] E3 = E2 + 27'(BG_SZ);
  localparam logic [26:0] E4 = E3 + 27'(SPR_SZ);
  localparam logic [26:0] E5 = E4 + 27'(MAP_SZ);
  localparam logic [26:0] E6 = E5 + 27'(PROM_SZ);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e      state_q, state_d;
  logic        act, act_q, act_rise, act_fall, strobe;
  logic        load_lo, load_hi, adv, fire, drop;
  logic [26:0] addr_q;
  logic [7:0]  hi_q, data_q;
  logic [2:0]  region_q;
  logic [16:0] off_q;
  logic        ok_q;
  logic        wait_q, done_q, err_q, wrote_q, end_q;
  logic [26:0] dec_addr, dec_base;
  logic [2:0]  dec_region;
  logic [16:0] dec_off;
  logic        dec_ok;

  assign act      = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign strobe   = act && bus.ioctl_wr;
  assign act_rise = act && !act_q;
  assign act_fall = !act && act_q;

  // One decoder serves both bytes: the incoming address in IDLE, addr+1 afterwards.
  assign dec_addr = (state_q == StIdle) ? bus.ioctl_addr : addr_q + 27'd1;

  always_comb begin
    dec_ok     = 1'b1;
    dec_region = 3'd0;
    dec_base   = 27'd0;
    if (dec_addr < E0) begin
      dec_region = 3'd0;
    end else if (dec_addr < E1) begin
      dec_region = 3'd1;
      dec_base   = E0;
    end else if (dec_addr < E2) begin
      dec_region = 3'd2;
      dec_base   = E1;
    end else if (dec_addr < E3) begin
      dec_region = 3'd3;
      dec_base   = E2;
    end else if (dec_addr < E4) begin
      dec_region = 3'd4;
      dec_base   = E3;
    end else if (dec_addr < E5) begin
      dec_region = 3'd5;
      dec_base   = E4;
    end else if (dec_addr < E6) begin
      dec_region = 3'd6;
      dec_base   = E5;
    end else begin
      dec_ok     = 1'b0;
    end
    dec_off = 17'(dec_addr - dec_base);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (strobe) state_d = StLo;
      StLo:    if (adv) state_d = StHi;
      StHi:    if (adv) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Out-of-range bytes need no sink slot, so they advance even while busy.
  always_comb begin
    load_lo = 1'b0;
    load_hi = 1'b0;
    adv     = 1'b0;
    fire    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      StIdle: load_lo = strobe;
      StLo, StHi: begin
        adv     = !bus.rom_busy || !ok_q;
        fire    = ok_q && !bus.rom_busy;
        load_hi = adv && (state_q == StLo);
        drop    = strobe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      hi_q     <= '0;
      data_q   <= '0;
      region_q <= '0;
      off_q    <= '0;
      ok_q     <= 1'b0;
    end else if (load_lo) begin
      addr_q   <= bus.ioctl_addr;
      hi_q     <= bus.ioctl_dout[15:8];
      data_q   <= bus.ioctl_dout[7:0];
      region_q <= dec_region;
      off_q    <= dec_off;
      ok_q     <= dec_ok;
    end else if (load_hi) begin
      data_q   <= hi_q;
      region_q <= dec_region;
      off_q    <= dec_off;
      ok_q     <= dec_ok;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      act_q   <= 1'b0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wrote_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      act_q  <= act;
      wait_q <= (state_d != StIdle);
      if (act_rise) begin
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        wrote_q <= 1'b0;
        end_q   <= 1'b0;
      end
      if (fire) wrote_q <= 1'b1;
      if (drop || ((state_q != StIdle) && !ok_q)) err_q <= 1'b1;
      // A download end seen mid-word is held until the word has drained.
      if ((end_q || act_fall) && (state_q == StIdle)) begin
        if (wrote_q) done_q <= 1'b1;
        end_q <= 1'b0;
      end else if (act_fall) begin
        end_q <= 1'b1;
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.rom_wr     = fire;
  assign bus.rom_region = region_q;
  assign bus.rom_addr   = off_q;
  assign bus.rom_data   = data_q;
  assign bus.dl_done    = done_q;
  assign bus.dl_err     = err_q;

endmodule
